sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 117 +++++++++++
 tb/tb_sw_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Switch/key debouncer: two-flop synchronizer, four-state qualification FSM,
// registered level, edge pulses and a modulo-256 count of accepted presses.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       D_in,
    output logic       Q,
    output logic       Rise,
    output logic       Fall,
    output logic [7:0] Count
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
        $error("sw_debounce: DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (CNT_W < 32 && DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_width
        $error("sw_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        STABLE0,
        PEND1,
        STABLE1,
        PEND0
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             q_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic [7:0]       count_nxt;

    // Synchronizer and all architectural state; reset wins over any acceptance.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE0;
            cnt   <= '0;
            Q     <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
            Count <= 8'd0;
        end else begin
            s1    <= D_in;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Q     <= q_nxt;
            Rise  <= rise_nxt;
            Fall  <= fall_nxt;
            Count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        q_nxt     = Q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        count_nxt = Count;
        case (state)
            STABLE0: begin
                if (s2) begin
                    state_nxt = PEND1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PEND1: begin
                // A reversal, even on the would-be acceptance edge, restarts from zero.
                if (!s2) begin
                    state_nxt = STABLE0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE1;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                    count_nxt = Count + 8'd1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE1: begin
                if (!s2) begin
                    state_nxt = PEND0;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PEND0: begin
                if (s2) begin
                    state_nxt = STABLE1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE0;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE0;
            end
        endcase
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: per-cycle reference model, table of glitch/pulse
// vectors, hand-written corner sequences and randomized run-length stimulus.
module tb_sw_debounce;

    localparam int DC = 4;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       D_in = 1'b0;
    logic       Q;
    logic       Rise;
    logic       Fall;
    logic [7:0] Count;

    sw_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .D_in   (D_in),
        .Q      (Q),
        .Rise   (Rise),
        .Fall   (Fall),
        .Count  (Count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int nrise  = 0;
    int nfall  = 0;

    // Reference model: the input must differ from the accepted level for DC
    // consecutive synchronized samples before the level flips.
    logic       m_sync [2];
    logic       m_q;
    logic       m_rise;
    logic       m_fall;
    int         m_run;
    logic [7:0] m_count;

    typedef struct {
        logic base;
        int   len;
        logic exp_q;
        int   exp_rise;
        int   exp_fall;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input logic din, input logic rstn);
        if (!rstn) begin
            m_sync[0] = 1'b0;
            m_sync[1] = 1'b0;
            m_run     = 0;
            m_q       = 1'b0;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            m_count   = 8'd0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = (m_sync[1] != m_q) ? m_run + 1 : 0;
            if (m_run == DC) begin
                m_q    = ~m_q;
                m_run  = 0;
                m_rise = m_q;
                m_fall = ~m_q;
                if (m_q) m_count = m_count + 8'd1;
            end
            m_sync[1] = m_sync[0];
            m_sync[0] = din;
        end
    endfunction

    task automatic tick(input logic din, input logic rstn);
        D_in   = din;
        Resetn = rstn;
        @(posedge Clk);
        model_step(din, rstn);
        @(negedge Clk);
        check("model_q", {31'd0, Q}, {31'd0, m_q});
        check("model_rise", {31'd0, Rise}, {31'd0, m_rise});
        check("model_fall", {31'd0, Fall}, {31'd0, m_fall});
        check("model_count", {24'd0, Count}, {24'd0, m_count});
        if (Rise === 1'b1) nrise++;
        if (Fall === 1'b1) nfall++;
    endtask

    task automatic hold(input logic din, input int n);
        for (int i = 0; i < n; i++) tick(din, 1'b1);
    endtask

    initial begin
        int r0;
        int f0;
        int ticks;
        logic lvl;
        int len;

        m_sync[0] = 1'b0;
        m_sync[1] = 1'b0;
        m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_count = 8'd0;

        tbl[0] = '{1'b0, 1, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 2, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 3, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 4, 1'b0, 1, 1};
        tbl[4] = '{1'b0, 5, 1'b0, 1, 1};
        tbl[5] = '{1'b0, 7, 1'b0, 1, 1};
        tbl[6] = '{1'b1, 1, 1'b1, 0, 0};
        tbl[7] = '{1'b1, 3, 1'b1, 0, 0};
        tbl[8] = '{1'b1, 4, 1'b1, 1, 1};
        tbl[9] = '{1'b1, 6, 1'b1, 1, 1};

        // Reset state.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("reset_q", {31'd0, Q}, 32'd0);
        check("reset_count", {24'd0, Count}, 32'd0);
        hold(1'b0, 3);

        // Clean press: Q and Rise appear on the sixth edge after D_in rises.
        for (int i = 0; i <= 6; i++) begin
            tick(1'b1, 1'b1);
            check("press_q", {31'd0, Q}, (i >= 5) ? 32'd1 : 32'd0);
            check("press_rise", {31'd0, Rise}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("press_count", {24'd0, Count}, 32'd1);

        // Release.
        for (int i = 0; i <= 6; i++) begin
            tick(1'b0, 1'b1);
            check("release_q", {31'd0, Q}, (i >= 5) ? 32'd0 : 32'd1);
            check("release_fall", {31'd0, Fall}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("release_count", {24'd0, Count}, 32'd1);

        // Bounce 1,0,1,0 then settle high.
        r0 = nrise;
        tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
        check("bounce_no_rise", nrise - r0, 32'd0);
        for (int i = 0; i <= 6; i++) begin
            tick(1'b1, 1'b1);
            check("bounce_rise", {31'd0, Rise}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("bounce_rises", nrise - r0, 32'd1);
        check("bounce_count", {24'd0, Count}, 32'd2);
        hold(1'b0, 8);

        // Short glitch of three cycles.
        r0 = nrise;
        hold(1'b1, 3);
        hold(1'b0, 8);
        check("glitch_q", {31'd0, Q}, 32'd0);
        check("glitch_rise", nrise - r0, 32'd0);
        check("glitch_count", {24'd0, Count}, 32'd2);

        // Table of pulses against an established base level.
        for (int k = 0; k < 10; k++) begin
            hold(tbl[k].base, 10);
            r0 = nrise;
            f0 = nfall;
            hold(~tbl[k].base, tbl[k].len);
            hold(tbl[k].base, 10);
            check("tbl_q", {31'd0, Q}, {31'd0, tbl[k].exp_q});
            check("tbl_rise", nrise - r0, tbl[k].exp_rise);
            check("tbl_fall", nfall - f0, tbl[k].exp_fall);
        end
        hold(1'b0, 10);

        // Reset while in PEND1 with cnt=2, D_in held high throughout.
        hold(1'b1, 4);
        tick(1'b1, 1'b0);
        check("rstmid_q", {31'd0, Q}, 32'd0);
        check("rstmid_rise", {31'd0, Rise}, 32'd0);
        check("rstmid_fall", {31'd0, Fall}, 32'd0);
        check("rstmid_count", {24'd0, Count}, 32'd0);
        for (int i = 0; i <= 6; i++) begin
            tick(1'b1, 1'b1);
            check("rstmid_requal", {31'd0, Rise}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("rstmid_count1", {24'd0, Count}, 32'd1);
        hold(1'b0, 8);

        // 256 presses wrap the count back to where it started.
        r0 = nrise;
        f0 = nfall;
        for (int p = 0; p < 256; p++) begin
            hold(1'b1, 6);
            hold(1'b0, 6);
        end
        check("wrap_count", {24'd0, Count}, 32'd1);
        check("wrap_rises", nrise - r0, 32'd256);
        check("wrap_falls", nfall - f0, 32'd256);

        // Reset landing on the acceptance edge suppresses the acceptance.
        hold(1'b1, 5);
        tick(1'b1, 1'b0);
        check("rstacc_q", {31'd0, Q}, 32'd0);
        check("rstacc_rise", {31'd0, Rise}, 32'd0);
        hold(1'b0, 4);

        // Randomized run lengths with occasional resets.
        ticks = 0;
        while (ticks < 4000) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 63) == 0) begin
                tick(lvl, 1'b0);
                ticks++;
            end
            for (int i = 0; i < len; i++) tick(lvl, 1'b1);
            ticks += len;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
